// File: rtl/madd_arbiter.sv
// Round-robin two-port sequencer for the shared combinational WxW matrix adder.
// Latches the winner's operands, waits LAT settle cycles, captures the sum and pulses done.
module madd_arbiter #(
    parameter int bitlength = 8,
    parameter int W         = 7,
    parameter int LAT       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req0,
    input  logic                       req1,
    input  logic [W*W*bitlength-1:0]   a0,
    input  logic [W*W*bitlength-1:0]   b0,
    input  logic [W*W*bitlength-1:0]   a1,
    input  logic [W*W*bitlength-1:0]   b1,
    output logic [W*W*bitlength-1:0]   madd_a,
    output logic [W*W*bitlength-1:0]   madd_b,
    input  logic [W*W*bitlength-1:0]   madd_c,
    output logic [W*W*bitlength-1:0]   c_out,
    output logic                       done0,
    output logic                       done1,
    output logic                       gnt0,
    output logic                       gnt1,
    output logic                       busy
);
    localparam int MW = W * W * bitlength;
    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [MW-1:0] MAT_ZERO = {MW{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic [MW-1:0]   madd_a_q, madd_a_d;
    logic [MW-1:0]   madd_b_q, madd_b_d;
    logic [MW-1:0]   c_out_q, c_out_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            busy_q, busy_d;
    logic            accept_s;
    logic            capture_s;
    logic            win_s;

    // Winner pick: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        win_s = 1'b0;
        if (req0 && req1) begin
            win_s = ~last_q;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the accept/capture strobes that drive the datapath.
    always_comb begin
        state_d   = state_q;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    accept_s = 1'b1;
                    state_d  = S_WAIT;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    capture_s = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; everything holds unless the state acts on it.
    always_comb begin
        cnt_d    = cnt_q;
        last_d   = last_q;
        madd_a_d = madd_a_q;
        madd_b_d = madd_b_q;
        c_out_d  = c_out_q;
        done0_d  = done0_q;
        done1_d  = done1_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        busy_d   = busy_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    madd_a_d = win_s ? a1 : a0;
                    madd_b_d = win_s ? b1 : b0;
                    gnt0_d   = ~win_s;
                    gnt1_d   = win_s;
                    busy_d   = 1'b1;
                    last_d   = win_s;
                    cnt_d    = CNT_INIT;
                end else begin
                    busy_d   = busy_q;
                end
            end
            S_WAIT: begin
                if (capture_s) begin
                    c_out_d = madd_c;
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                // Unreachable encoding: drop all handshakes and recover through IDLE.
                done0_d = 1'b0;
                done1_d = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Datapath and handshake registers; last resets to 1 so req0 wins first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= CNT_ZERO;
            last_q   <= 1'b1;
            madd_a_q <= MAT_ZERO;
            madd_b_q <= MAT_ZERO;
            c_out_q  <= MAT_ZERO;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            madd_a_q <= madd_a_d;
            madd_b_q <= madd_b_d;
            c_out_q  <= c_out_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            busy_q   <= busy_d;
        end
    end

    assign madd_a = madd_a_q;
    assign madd_b = madd_b_q;
    assign c_out  = c_out_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign busy   = busy_q;

    madd_arbiter_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .done0 (done0_q),
        .done1 (done1_q),
        .gnt0  (gnt0_q),
        .gnt1  (gnt1_q),
        .busy  (busy_q)
    );

endmodule

// Handshake invariants of the arbiter's registered outputs.
module madd_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic done0,
    input logic done1,
    input logic gnt0,
    input logic gnt1,
    input logic busy
);
    a_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done0 && done1));
    a_gnt_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
    a_done_gnt:  assert property (@(posedge clk) disable iff (!rst_n) (!done0 || gnt0) && (!done1 || gnt1));
    a_busy_gnt:  assert property (@(posedge clk) disable iff (!rst_n) busy == (gnt0 || gnt1));
endmodule

// File: tb/tb_madd_arbiter.sv
// Bench for madd_arbiter: one LAT=1 and one LAT=4 instance, each with a behavioural adder,
// driven by directed and randomized transactions against a transaction-level model.
module tb_madd_arbiter;
    localparam int BL = 8;
    localparam int W  = 7;
    localparam int E  = W * W;
    localparam int N  = E * BL;

    logic clk = 1'b0;
    logic rst_n_s [2];
    logic req0_s  [2];
    logic req1_s  [2];
    logic [N-1:0] a0_s [2];
    logic [N-1:0] b0_s [2];
    logic [N-1:0] a1_s [2];
    logic [N-1:0] b1_s [2];
    logic [N-1:0] madd_a_s [2];
    logic [N-1:0] madd_b_s [2];
    logic [N-1:0] madd_c_s [2];
    logic [N-1:0] c_out_s  [2];
    logic done0_s [2];
    logic done1_s [2];
    logic gnt0_s  [2];
    logic gnt1_s  [2];
    logic busy_s  [2];

    int checks;
    int errors;
    int cyc = 0;
    int accept_cyc [2];
    logic model_last [2];
    logic [N-1:0] late_a0, late_b0, late_a1, late_b1;

    function automatic logic [N-1:0] mat_add(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] s;
        s = {N{1'b0}};
        for (int e = 0; e < E; e++) s[e*BL +: BL] = x[e*BL +: BL] + y[e*BL +: BL];
        return s;
    endfunction

    function automatic logic [N-1:0] fill(input logic [BL-1:0] v);
        logic [N-1:0] m;
        m = {N{1'b0}};
        for (int e = 0; e < E; e++) m[e*BL +: BL] = v;
        return m;
    endfunction

    function automatic logic [N-1:0] rand_mat();
        logic [N-1:0] m;
        m = {N{1'b0}};
        for (int e = 0; e < E; e++) m[e*BL +: BL] = 8'($urandom_range(255));
        return m;
    endfunction

    function automatic string tg(input int k, input string s);
        return $sformatf("k%0d_%s", k, s);
    endfunction

    // The shared adder lives outside the arbiter; model it here.
    assign madd_c_s[0] = mat_add(madd_a_s[0], madd_b_s[0]);
    assign madd_c_s[1] = mat_add(madd_a_s[1], madd_b_s[1]);

    madd_arbiter #(.bitlength(BL), .W(W), .LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n_s[0]), .req0(req0_s[0]), .req1(req1_s[0]),
        .a0(a0_s[0]), .b0(b0_s[0]), .a1(a1_s[0]), .b1(b1_s[0]),
        .madd_a(madd_a_s[0]), .madd_b(madd_b_s[0]), .madd_c(madd_c_s[0]), .c_out(c_out_s[0]),
        .done0(done0_s[0]), .done1(done1_s[0]), .gnt0(gnt0_s[0]), .gnt1(gnt1_s[0]), .busy(busy_s[0])
    );

    madd_arbiter #(.bitlength(BL), .W(W), .LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n_s[1]), .req0(req0_s[1]), .req1(req1_s[1]),
        .a0(a0_s[1]), .b0(b0_s[1]), .a1(a1_s[1]), .b1(b1_s[1]),
        .madd_a(madd_a_s[1]), .madd_b(madd_b_s[1]), .madd_c(madd_c_s[1]), .c_out(c_out_s[1]),
        .done0(done0_s[1]), .done1(done1_s[1]), .gnt0(gnt0_s[1]), .gnt1(gnt1_s[1]), .busy(busy_s[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkm(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete transaction starting from IDLE; expectations come from the model.
    task automatic txn(input int k, input logic r0, input logic r1, input logic keep,
                       output logic obs_win);
        logic win;
        logic [N-1:0] ea, eb, ec;
        int lat;
        lat = (k == 0) ? 1 : 4;
        win = (r0 && r1) ? !model_last[k] : r1;
        model_last[k] = win;
        ea = win ? a1_s[k] : a0_s[k];
        eb = win ? b1_s[k] : b0_s[k];
        ec = mat_add(ea, eb);
        req0_s[k] = r0;
        req1_s[k] = r1;
        @(posedge clk); #1;
        accept_cyc[k] = cyc;
        obs_win = gnt1_s[k];
        chk1(tg(k, "acc_gnt0"), gnt0_s[k], !win);
        chk1(tg(k, "acc_gnt1"), gnt1_s[k], win);
        chk1(tg(k, "acc_busy"), busy_s[k], 1'b1);
        chk1(tg(k, "acc_done0"), done0_s[k], 1'b0);
        chk1(tg(k, "acc_done1"), done1_s[k], 1'b0);
        chkm(tg(k, "acc_madd_a"), madd_a_s[k], ea);
        chkm(tg(k, "acc_madd_b"), madd_b_s[k], eb);
        a0_s[k] = late_a0;
        b0_s[k] = late_b0;
        a1_s[k] = late_a1;
        b1_s[k] = late_b1;
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (c < lat) begin
                chk1(tg(k, "wait_done0"), done0_s[k], 1'b0);
                chk1(tg(k, "wait_done1"), done1_s[k], 1'b0);
                chk1(tg(k, "wait_busy"), busy_s[k], 1'b1);
                chkm(tg(k, "wait_madd_a"), madd_a_s[k], ea);
                chkm(tg(k, "wait_madd_b"), madd_b_s[k], eb);
            end else begin
                chk1(tg(k, "cap_done0"), done0_s[k], !win);
                chk1(tg(k, "cap_done1"), done1_s[k], win);
                chk1(tg(k, "cap_gnt0"), gnt0_s[k], !win);
                chk1(tg(k, "cap_gnt1"), gnt1_s[k], win);
                chkm(tg(k, "cap_c_out"), c_out_s[k], ec);
                chkm(tg(k, "cap_madd_a"), madd_a_s[k], ea);
            end
        end
        if (!keep) begin
            if (win) req1_s[k] = 1'b0;
            else     req0_s[k] = 1'b0;
        end
        @(posedge clk); #1;
        chk1(tg(k, "end_done0"), done0_s[k], 1'b0);
        chk1(tg(k, "end_done1"), done1_s[k], 1'b0);
        chk1(tg(k, "end_gnt0"), gnt0_s[k], 1'b0);
        chk1(tg(k, "end_gnt1"), gnt1_s[k], 1'b0);
        chk1(tg(k, "end_busy"), busy_s[k], 1'b0);
        chkm(tg(k, "end_c_out"), c_out_s[k], ec);
    endtask

    initial begin
        logic w, r0, r1, p0, p1;
        logic [N-1:0] exp1;
        int prev;
        checks = 0;
        errors = 0;
        late_a0 = {N{1'b0}};
        late_b0 = {N{1'b0}};
        late_a1 = {N{1'b0}};
        late_b1 = {N{1'b0}};
        for (int k = 0; k < 2; k++) begin
            rst_n_s[k] = 1'b0;
            req0_s[k] = 1'b0;
            req1_s[k] = 1'b0;
            a0_s[k] = rand_mat();
            b0_s[k] = rand_mat();
            a1_s[k] = rand_mat();
            b1_s[k] = rand_mat();
            model_last[k] = 1'b1;
            accept_cyc[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chkm(tg(k, "rst_madd_a"), madd_a_s[k], {N{1'b0}});
            chkm(tg(k, "rst_madd_b"), madd_b_s[k], {N{1'b0}});
            chkm(tg(k, "rst_c_out"), c_out_s[k], {N{1'b0}});
            chk1(tg(k, "rst_done0"), done0_s[k], 1'b0);
            chk1(tg(k, "rst_done1"), done1_s[k], 1'b0);
            chk1(tg(k, "rst_gnt0"), gnt0_s[k], 1'b0);
            chk1(tg(k, "rst_gnt1"), gnt1_s[k], 1'b0);
            chk1(tg(k, "rst_busy"), busy_s[k], 1'b0);
            rst_n_s[k] = 1'b1;
        end
        @(posedge clk); #1;

        // Single transaction: a0=2i+j, b0=2i+j+1, sum 4i+2j+1.
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                a0_s[0][(i*W+j)*BL +: BL] = 8'(2*i + j);
                b0_s[0][(i*W+j)*BL +: BL] = 8'(2*i + j + 1);
                exp1[(i*W+j)*BL +: BL]    = 8'(4*i + 2*j + 1);
            end
        end
        late_a0 = rand_mat();
        late_b0 = rand_mat();
        txn(0, 1'b1, 1'b0, 1'b0, w);
        chki("k0_single_c00", int'(c_out_s[0][0 +: BL]), 1);
        chki("k0_single_c66", int'(c_out_s[0][384 +: BL]), 37);
        chkm("k0_single_all", c_out_s[0], exp1);

        // Wrap: 200 + 100 = 44 mod 256.
        a1_s[0] = fill(8'd200);
        b1_s[0] = fill(8'd100);
        txn(0, 1'b0, 1'b1, 1'b0, w);
        chk1("k0_wrap_winner", w, 1'b1);
        chkm("k0_wrap_c_out", c_out_s[0], fill(8'd44));

        // Idle with no requests: everything holds.
        repeat (3) @(posedge clk);
        #1;
        chk1("k0_idle_busy", busy_s[0], 1'b0);
        chkm("k0_idle_c_out", c_out_s[0], fill(8'd44));
        chkm("k0_idle_madd_a", madd_a_s[0], fill(8'd200));

        // Contention: order 0,1,0,1 with back-to-back accepts LAT+2 apart.
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            a0_s[0] = rand_mat(); b0_s[0] = rand_mat();
            a1_s[0] = rand_mat(); b1_s[0] = rand_mat();
            late_a0 = rand_mat(); late_b0 = rand_mat();
            late_a1 = rand_mat(); late_b1 = rand_mat();
            txn(0, 1'b1, 1'b1, 1'b0, w);
            chk1($sformatf("k0_cont_order%0d", i), w, (i % 2) == 1);
            if (i > 0) chki($sformatf("k0_cont_spacing%0d", i), accept_cyc[0] - prev, 3);
            prev = accept_cyc[0];
        end
        req0_s[0] = 1'b0;
        req1_s[0] = 1'b0;
        @(posedge clk); #1;

        // Held request: req0 stays high past done, re-accepted at E_LAT+2.
        a0_s[0] = rand_mat(); b0_s[0] = rand_mat();
        txn(0, 1'b1, 1'b0, 1'b1, w);
        prev = accept_cyc[0];
        a0_s[0] = rand_mat(); b0_s[0] = rand_mat();
        txn(0, 1'b1, 1'b0, 1'b0, w);
        chki("k0_held_spacing", accept_cyc[0] - prev, 3);

        // Operand isolation on LAT=4: a0 3 -> 9 during WAIT must not matter.
        a0_s[1] = fill(8'd3);
        b0_s[1] = fill(8'd1);
        late_a0 = fill(8'd9);
        late_b0 = fill(8'd1);
        txn(1, 1'b1, 1'b0, 1'b0, w);
        chkm("k1_iso_c_out", c_out_s[1], fill(8'd4));

        // Reset two cycles after accept: abandoned with no done pulse.
        a0_s[1] = rand_mat();
        req0_s[1] = 1'b1;
        @(posedge clk); #1;
        chk1("k1_rstw_acc_gnt0", gnt0_s[1], 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n_s[1] = 1'b0;
        #1;
        chkm("k1_rstw_madd_a", madd_a_s[1], {N{1'b0}});
        chkm("k1_rstw_madd_b", madd_b_s[1], {N{1'b0}});
        chkm("k1_rstw_c_out", c_out_s[1], {N{1'b0}});
        chk1("k1_rstw_gnt0", gnt0_s[1], 1'b0);
        chk1("k1_rstw_gnt1", gnt1_s[1], 1'b0);
        chk1("k1_rstw_busy", busy_s[1], 1'b0);
        req0_s[1] = 1'b0;
        model_last[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk1("k1_rstw_no_done0", done0_s[1], 1'b0);
        end
        rst_n_s[1] = 1'b1;
        @(posedge clk); #1;
        chk1("k1_rstw_idle_busy", busy_s[1], 1'b0);
        chk1("k1_rstw_idle_done0", done0_s[1], 1'b0);
        txn(1, 1'b1, 1'b1, 1'b0, w);
        chk1("k1_rstw_cont_first", w, 1'b0);
        txn(1, 1'b1, 1'b1, 1'b0, w);
        chk1("k1_rstw_cont_second", w, 1'b1);
        req0_s[1] = 1'b0;
        req1_s[1] = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic on both instances; a losing request stays raised.
        for (int k = 0; k < 2; k++) begin
            p0 = 1'b0;
            p1 = 1'b0;
            for (int n = 0; n < 12; n++) begin
                r0 = 1'($urandom_range(1)) | p0;
                r1 = 1'($urandom_range(1)) | p1;
                if (!r0 && !r1) r0 = 1'b1;
                a0_s[k] = rand_mat(); b0_s[k] = rand_mat();
                a1_s[k] = rand_mat(); b1_s[k] = rand_mat();
                late_a0 = rand_mat(); late_b0 = rand_mat();
                late_a1 = rand_mat(); late_b1 = rand_mat();
                txn(k, r0, r1, 1'b0, w);
                p0 = r0 && w;
                p1 = r1 && !w;
            end
            req0_s[k] = 1'b0;
            req1_s[k] = 1'b0;
            @(posedge clk); #1;
            chk1(tg(k, "rand_tail_busy"), busy_s[k], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
